// File: rtl/cpu_ctrl32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl32_pkg
// Description : Shared constants for the RV32I multi-cycle control sequencer.
//               Holds the opcode constants for the ten instruction classes,
//               the 3-bit state encodings, the wb_sel/pc_sel encodings and
//               the one-hot opcode class structure.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl32_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] c_OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] c_OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_ENV    = 7'b1110011;

    // Sequencer state encodings
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    typedef enum logic [2:0] {
        ST_FETCH  = c_ST_FETCH,
        ST_DECODE = c_ST_DECODE,
        ST_EXEC   = c_ST_EXEC,
        ST_MEM    = c_ST_MEM,
        ST_WB     = c_ST_WB,
        ST_HALT   = c_ST_HALT,
        ST_ERR    = c_ST_ERR
    } state_t;

    // Register-file write-back source
    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    // Next-PC source
    localparam logic [1:0] c_PC_PLUS4 = 2'd0;
    localparam logic [1:0] c_PC_IMM   = 2'd1;
    localparam logic [1:0] c_PC_ALU   = 2'd2;

    // One-hot opcode class
    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic env;
    } opclass_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_opclass32.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_opclass32
// Description : Combinational RV32I opcode classifier.
//               opcode  : in  7  raw inst[6:0]
//               opclass : out    one-hot class (all zero when illegal)
//               illegal : out 1  opcode matches none of the ten classes
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_opclass32
    import cpu_ctrl32_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass,
    output logic       illegal
);

    always_comb begin
        opclass = '0;
        case (opcode)
            c_OP_ALU_R:  opclass.alu_r  = 1'b1;
            c_OP_ALU_I:  opclass.alu_i  = 1'b1;
            c_OP_LOAD:   opclass.load   = 1'b1;
            c_OP_STORE:  opclass.store  = 1'b1;
            c_OP_BRANCH: opclass.branch = 1'b1;
            c_OP_JAL:    opclass.jal    = 1'b1;
            c_OP_JALR:   opclass.jalr   = 1'b1;
            c_OP_LUI:    opclass.lui    = 1'b1;
            c_OP_AUIPC:  opclass.auipc  = 1'b1;
            c_OP_ENV:    opclass.env    = 1'b1;
            default:     opclass        = '0;
        endcase
        illegal = ~|opclass;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl32.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl32
// Description : Multi-cycle RV32I control sequencer
//               (FETCH/DECODE/EXEC/MEM/WB, plus sticky HALT and ERR).
//               Ports:
//                 clk, rst                   clock / sync active-high reset
//                 opcode, branch_taken       from decode unit / ALU
//                 ifu_req/ifu_ack, ir_we     instruction fetch handshake
//                 lsu_req/lsu_we/lsu_ack     data memory handshake
//                 rf_we, wb_sel              register-file write control
//                 pc_we, pc_sel              PC update control
//                 halt, err                  sticky status
//                 instret                    retired instruction count
//                 state                      current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl32
    import cpu_ctrl32_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    output logic             ifu_req,
    input  logic             ifu_ack,
    output logic             ir_we,
    output logic             lsu_req,
    output logic             lsu_we,
    input  logic             lsu_ack,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             halt,
    output logic             err,
    output logic [WIDTH-1:0] instret,
    output logic [2:0]       state
);

    // Counter only needs to reach ACK_TIMEOUT-1
    localparam int              c_TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);

    state_t             r_state;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [WIDTH-1:0]   r_instret;
    logic               r_halt;
    logic               r_err;

    opclass_t           w_cls;
    logic               w_illegal;
    logic               w_to_last;
    logic               w_to_wb;

    ctrl_opclass32 u_opclass (
        .opcode  (opcode),
        .opclass (w_cls),
        .illegal (w_illegal)
    );

    assign w_to_last = (r_to_cnt == c_TO_LAST);
    // Classes that skip the memory phase and go straight to write-back
    assign w_to_wb   = w_cls.alu_r | w_cls.alu_i | w_cls.branch | w_cls.jal |
                       w_cls.jalr  | w_cls.lui   | w_cls.auipc;

    // Strobes: decoded from state, with ir_we and store retirement qualified
    // by the ack of the current cycle. Reset kills every strobe at once.
    always_comb begin
        ifu_req = 1'b0;
        ir_we   = 1'b0;
        lsu_req = 1'b0;
        lsu_we  = 1'b0;
        rf_we   = 1'b0;
        wb_sel  = c_WB_ALU;
        pc_we   = 1'b0;
        pc_sel  = c_PC_PLUS4;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    ifu_req = 1'b1;
                    ir_we   = ifu_ack;
                end
                ST_MEM: begin
                    lsu_req = 1'b1;
                    lsu_we  = w_cls.store;
                    pc_we   = lsu_ack & w_cls.store;
                end
                ST_WB: begin
                    pc_we = 1'b1;
                    rf_we = ~w_cls.branch;
                    if (w_cls.load)
                        wb_sel = c_WB_MEM;
                    else if (w_cls.jal | w_cls.jalr)
                        wb_sel = c_WB_PC4;
                    if (w_cls.jalr)
                        pc_sel = c_PC_ALU;
                    else if (w_cls.jal | (w_cls.branch & branch_taken))
                        pc_sel = c_PC_IMM;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_to_cnt  <= '0;
            r_instret <= '0;
            r_halt    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // pc_we marks every retirement (WB, or store ack in MEM)
            if (pc_we)
                r_instret <= r_instret + 1'b1;
            case (r_state)
                ST_FETCH: begin
                    if (ifu_ack) begin
                        r_state <= ST_DECODE;
                    end else if (w_to_last) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_cls.env) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end else if (w_illegal) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_cls.load | w_cls.store) begin
                        r_state  <= ST_MEM;
                        r_to_cnt <= '0;
                    end else if (w_to_wb) begin
                        r_state <= ST_WB;
                    end else begin
                        // opcode changed after DECODE: treat as illegal
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (lsu_ack) begin
                        if (w_cls.store) begin
                            r_state  <= ST_FETCH;
                            r_to_cnt <= '0;
                        end else begin
                            r_state <= ST_WB;
                        end
                    end else if (w_to_last) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    r_state  <= ST_FETCH;
                    r_to_cnt <= '0;
                end
                ST_HALT: r_state <= ST_HALT;
                ST_ERR:  r_state <= ST_ERR;
                default: begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign halt    = r_halt;
    assign err     = r_err;
    assign instret = r_instret;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl32.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ctrl32
// Description : Scoreboard bench for cpu_ctrl32 (WIDTH=4, ACK_TIMEOUT=4).
//               The driver pushes the expected retirement of every
//               instruction it issues; a monitor pops and compares each
//               time the DUT retires (pc_we). Halt, error, timeout and
//               reset behaviour are checked directly by the driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl32;

    localparam int W  = 4;
    localparam int TO = 4;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEM = 3'd3,
                           S_HALT  = 3'd5, S_ERR    = 3'd6;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   opcode;
    logic         branch_taken;
    logic         ifu_req, ifu_ack, ir_we;
    logic         lsu_req, lsu_we, lsu_ack;
    logic         rf_we, pc_we;
    logic [1:0]   wb_sel, pc_sel;
    logic         halt, err;
    logic [W-1:0] instret;
    logic [2:0]   state;

    cpu_ctrl32 #(.WIDTH(W), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ir_we(ir_we),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .halt(halt), .err(err), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cycles;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       chk_wb;
        logic [1:0] pc_sel;
        int         lsu_cyc;
        int         lsu_we_cyc;
        logic [W-1:0] instret;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_instret = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int m_cyc = 0, m_ir = 0, m_lsu = 0, m_lwe = 0;
    always @(negedge clk) begin
        if (rst) begin
            m_cyc = 0; m_ir = 0; m_lsu = 0; m_lwe = 0;
        end else begin
            m_cyc++;
            if (ir_we)   m_ir++;
            if (lsu_req) m_lsu++;
            if (lsu_we)  m_lwe++;
            if (pc_we) begin
                if (sb.size() == 0) begin
                    chk("retire_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cycles",    m_cyc,         e.cycles);
                    chk("ir_we_cyc", m_ir,          1);
                    chk("rf_we",     {31'd0, rf_we}, {31'd0, e.rf_we});
                    if (e.chk_wb)
                        chk("wb_sel", {30'd0, wb_sel}, {30'd0, e.wb_sel});
                    chk("pc_sel",    {30'd0, pc_sel}, {30'd0, e.pc_sel});
                    chk("lsu_req_cyc", m_lsu,       e.lsu_cyc);
                    chk("lsu_we_cyc",  m_lwe,       e.lsu_we_cyc);
                    chk("instret",   {28'd0, instret}, {28'd0, e.instret});
                end
                m_cyc = 0; m_ir = 0; m_lsu = 0; m_lwe = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // fw/mw: ack wait cycles before fetch / memory ack
    task automatic run(input logic [6:0] op, input int fw, input int mw, input logic tk,
                       input int cyc_e, input logic rf_e, input logic [1:0] wb_e,
                       input logic chk_wb, input logic [1:0] pc_e,
                       input int lsu_e, input int lwe_e);
        exp_t e;
        e.cycles = cyc_e; e.rf_we = rf_e; e.wb_sel = wb_e; e.chk_wb = chk_wb;
        e.pc_sel = pc_e; e.lsu_cyc = lsu_e; e.lsu_we_cyc = lwe_e;
        e.instret = exp_instret;
        sb.push_back(e);
        exp_instret = exp_instret + 1'b1;
        opcode = op;
        branch_taken = tk;
        repeat (fw) tick();
        ifu_ack = 1'b1; tick(); ifu_ack = 1'b0;
        if (op == 7'h03 || op == 7'h23) begin
            repeat (2 + mw) tick();
            lsu_ack = 1'b1; tick(); lsu_ack = 1'b0;
            if (op == 7'h03) tick();
        end else begin
            repeat (3) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1; opcode = 7'h13; branch_taken = 1'b0;
        ifu_ack = 1'b0; lsu_ack = 1'b0;
        repeat (3) tick();
        chk("rst_ifu_req", {31'd0, ifu_req}, 0);
        chk("rst_pc_we",   {31'd0, pc_we},   0);
        chk("rst_state",   {29'd0, state},   {29'd0, S_FETCH});
        chk("rst_instret", {28'd0, instret}, 0);
        chk("rst_halt",    {31'd0, halt},    0);
        chk("rst_err",     {31'd0, err},     0);
        rst = 1'b0;
        #1;
        chk("post_rst_ifu_req", {31'd0, ifu_req}, 1);

        //  op     fw mw tk cyc rf wb  cw pc lsu lwe
        run(7'h13, 0, 0, 0, 4,  1, 0, 1, 0, 0, 0);   // ADDI
        run(7'h03, 0, 3, 0, 8,  1, 1, 1, 0, 4, 0);   // LW, 3 wait cycles
        run(7'h23, 0, 0, 0, 4,  0, 0, 0, 0, 1, 1);   // SW
        run(7'h63, 0, 0, 1, 4,  0, 0, 1, 1, 0, 0);   // BEQ taken
        run(7'h63, 0, 0, 0, 4,  0, 0, 1, 0, 0, 0);   // BEQ not taken
        run(7'h6F, 0, 0, 0, 4,  1, 2, 1, 1, 0, 0);   // JAL
        run(7'h67, 0, 0, 0, 4,  1, 2, 1, 2, 0, 0);   // JALR
        run(7'h37, 3, 0, 0, 7,  1, 0, 1, 0, 0, 0);   // LUI, fetch ack on last allowed cycle
        run(7'h17, 0, 0, 0, 4,  1, 0, 1, 0, 0, 0);   // AUIPC
        run(7'h33, 0, 0, 0, 4,  1, 0, 1, 0, 0, 0);   // ADD
        run(7'h23, 0, 3, 0, 7,  0, 0, 0, 0, 4, 4);   // SW, ack on last allowed cycle
        for (int i = 0; i < 6; i++)                  // instret 11..15 then wrap to 0
            run(7'h13, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        chk("instret_wrapped", {28'd0, instret}, 1);
        chk("sb_drained", sb.size(), 0);

        // Reset during MEM
        opcode = 7'h03;
        ifu_ack = 1'b1; tick(); ifu_ack = 1'b0;
        tick(); tick();
        chk("mem_state",   {29'd0, state},   {29'd0, S_MEM});
        chk("mem_lsu_req", {31'd0, lsu_req}, 1);
        rst = 1'b1;
        #1;
        chk("abort_lsu_req", {31'd0, lsu_req}, 0);
        chk("abort_strobes", {30'd0, pc_we, rf_we}, 0);
        tick();
        chk("abort_state",   {29'd0, state},   {29'd0, S_FETCH});
        chk("abort_instret", {28'd0, instret}, 0);
        chk("abort_lsu_req2", {31'd0, lsu_req}, 0);
        rst = 1'b0;
        exp_instret = '0;

        // Fetch timeout
        opcode = 7'h13;
        repeat (3) tick();
        chk("to_still_fetch", {29'd0, state}, {29'd0, S_FETCH});
        chk("to_err_early",   {31'd0, err},   0);
        tick();
        chk("to_state", {29'd0, state},   {29'd0, S_ERR});
        chk("to_err",   {31'd0, err},     1);
        chk("to_ifu_req", {31'd0, ifu_req}, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("to_err_cleared", {31'd0, err}, 0);

        // Illegal opcode
        opcode = 7'h7F;
        ifu_ack = 1'b1; tick(); ifu_ack = 1'b0;
        chk("ill_decode", {29'd0, state}, {29'd0, S_DECODE});
        tick();
        chk("ill_state", {29'd0, state}, {29'd0, S_ERR});
        chk("ill_err",   {31'd0, err},   1);
        rst = 1'b1; tick(); rst = 1'b0;

        // ECALL halts
        opcode = 7'h73;
        ifu_ack = 1'b1; tick(); ifu_ack = 1'b0;
        chk("env_decode_halt", {31'd0, halt}, 0);
        tick();
        chk("env_halt",  {31'd0, halt},  1);
        chk("env_state", {29'd0, state}, {29'd0, S_HALT});
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            ifu_ack = i[0];
            if (ifu_req | ir_we | lsu_req | pc_we | rf_we) cnt++;
            tick();
        end
        ifu_ack = 1'b0;
        chk("halt_strobes", cnt, 0);
        chk("halt_sticky", {31'd0, halt}, 1);
        rst = 1'b1; tick();
        chk("halt_cleared", {31'd0, halt}, 0);
        rst = 1'b0;
        #1;
        chk("halt_rst_ifu_req", {31'd0, ifu_req}, 1);
        chk("sb_final", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
